// File: rtl/codec_sample_fifo_pkg.sv
// Shared definitions for the codec sample FIFO: sample width, state encoding and defaults.
package codec_sample_fifo_pkg;

  localparam int SAMPLE_WIDTH     = 16;
  localparam int FIFO_ADDR_BITS   = 3;
  localparam int FIFO_PRIME_LEVEL = 4;

  // FILL waits for enough samples to absorb jitter; RUN releases one sample per frame.
  typedef enum logic {
    FIFO_FILL = 1'b0,
    FIFO_RUN  = 1'b1
  } fifo_state_e;

endpackage

// File: rtl/codec_sample_fifo_ram.sv
// Sample storage for the codec FIFO: one synchronous write port, one asynchronous read port.
// Contents are not reset; only the pointers in the parent decide what is valid.
module codec_sample_fifo_ram #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Store the incoming sample at the write address when a write is accepted.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/codec_sample_fifo.sv
// Elastic buffer between the echo stage and the codec. Samples enter on in_ready, leave
// attenuated on new_frame; an empty pop in RUN holds the last sample and re-primes.
module codec_sample_fifo
  import codec_sample_fifo_pkg::*;
#(
  parameter int WIDTH       = SAMPLE_WIDTH,
  parameter int ADDR_BITS   = FIFO_ADDR_BITS,
  parameter int PRIME_LEVEL = FIFO_PRIME_LEVEL
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     sample_in,
  input  logic                 in_ready,
  input  logic                 new_frame,
  input  logic [2:0]           vol,
  input  logic                 clear_flags,
  output logic [WIDTH-1:0]     sample_out,
  output logic                 sample_valid,
  output logic [ADDR_BITS:0]   fill_level,
  output logic                 underflow,
  output logic                 overflow
);

  localparam int                 CW        = ADDR_BITS + 1;
  localparam int                 DEPTH     = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [ADDR_BITS:0] PRIME_CNT = CW'(PRIME_LEVEL);

  fifo_state_e              r_state;
  fifo_state_e              w_nextState;
  logic [ADDR_BITS:0]       r_count;
  logic [ADDR_BITS-1:0]     r_wrPtr;
  logic [ADDR_BITS-1:0]     r_rdPtr;
  logic [WIDTH-1:0]         r_sampleOut;
  logic                     r_sampleValid;
  logic                     r_underflow;
  logic                     r_overflow;

  logic                     w_full;
  logic                     w_empty;
  logic                     w_pop;
  logic                     w_write;
  logic                     w_underflowEvt;
  logic                     w_overflowEvt;
  logic [WIDTH-1:0]         w_head;
  logic signed [WIDTH-1:0]  w_headSigned;
  logic signed [WIDTH-1:0]  w_attenuated;

  assign w_full       = (r_count == DEPTH_CNT);
  assign w_empty      = (r_count == '0);
  assign w_headSigned = w_head;
  assign w_attenuated = w_headSigned >>> vol;

  codec_sample_fifo_ram #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (w_write),
    .waddr (r_wrPtr),
    .wdata (sample_in),
    .raddr (r_rdPtr),
    .rdata (w_head)
  );

  // State register; FILL on reset so the codec never sees an unprimed buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FIFO_FILL;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Decode pops, writes and error events, and pick the next state from the registered count.
  always_comb begin
    w_nextState    = r_state;
    w_pop          = 1'b0;
    w_underflowEvt = 1'b0;
    unique case (r_state)
      FIFO_FILL: begin
        if (r_count >= PRIME_CNT) begin
          w_nextState = FIFO_RUN;
        end
      end
      FIFO_RUN: begin
        if (new_frame && !w_empty) begin
          w_pop = 1'b1;
        end else if (new_frame && w_empty) begin
          w_underflowEvt = 1'b1;
          w_nextState    = FIFO_FILL;
        end
      end
      default: w_nextState = FIFO_FILL;
    endcase
    // A pop in the same cycle frees the slot, so a write into a full buffer still lands.
    w_write       = in_ready && (!w_full || w_pop);
    w_overflowEvt = in_ready && w_full && !w_pop;
  end

  // Pointers and occupancy counter; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_write) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_write && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_write && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Codec-side outputs: every frame request gets a valid pulse, only a real pop changes the value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sampleOut   <= '0;
      r_sampleValid <= 1'b0;
    end else begin
      r_sampleValid <= new_frame;
      if (w_pop) begin
        r_sampleOut <= w_attenuated;
      end
    end
  end

  // Sticky error flags; a new event outranks a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_underflowEvt) begin
        r_underflow <= 1'b1;
      end else if (clear_flags) begin
        r_underflow <= 1'b0;
      end
      if (w_overflowEvt) begin
        r_overflow <= 1'b1;
      end else if (clear_flags) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign sample_out   = r_sampleOut;
  assign sample_valid = r_sampleValid;
  assign fill_level   = r_count;
  assign underflow    = r_underflow;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_codec_sample_fifo.sv
// Self-checking bench for codec_sample_fifo: directed scenarios plus random traffic,
// compared against a queue-based reference model of the buffer.
module tb_codec_sample_fifo;

  logic        clk;
  logic        reset;
  logic [15:0] sampleIn;
  logic        inReady;
  logic        newFrame;
  logic [2:0]  vol;
  logic        clearFlags;
  logic [15:0] sampleOut;
  logic        sampleValid;
  logic [3:0]  fillLevel;
  logic        underflow;
  logic        overflow;

  int checks;
  int errors;

  // Reference model state
  logic signed [15:0] modelQ[$];
  bit                 modelRun;
  logic signed [15:0] modelOut;
  bit                 modelValid;
  bit                 modelUf;
  bit                 modelOf;

  codec_sample_fifo #(
    .WIDTH       (16),
    .ADDR_BITS   (3),
    .PRIME_LEVEL (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sampleIn),
    .in_ready     (inReady),
    .new_frame    (newFrame),
    .vol          (vol),
    .clear_flags  (clearFlags),
    .sample_out   (sampleOut),
    .sample_valid (sampleValid),
    .fill_level   (fillLevel),
    .underflow    (underflow),
    .overflow     (overflow)
  );

  // 100 MHz free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic resetModel();
    modelQ.delete();
    modelRun   = 1'b0;
    modelOut   = '0;
    modelValid = 1'b0;
    modelUf    = 1'b0;
    modelOf    = 1'b0;
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".out"},   int'($signed(sampleOut)), int'(modelOut));
    checkOutput({tag, ".valid"}, int'(sampleValid), int'(modelValid));
    checkOutput({tag, ".fill"},  int'(fillLevel), modelQ.size());
    checkOutput({tag, ".uf"},    int'(underflow), int'(modelUf));
    checkOutput({tag, ".of"},    int'(overflow), int'(modelOf));
  endtask

  // Drive one cycle of inputs, advance the model by the buffer's rules, then compare.
  task automatic applyStimulus(input bit ir, input logic signed [15:0] data, input bit nf,
                               input logic [2:0] v, input bit clr, input string tag);
    int                 sz;
    bit                 full;
    bit                 pop;
    bit                 ufEvt;
    bit                 ofEvt;
    bit                 wr;
    bit                 nextRun;
    logic signed [15:0] head;
    @(negedge clk);
    inReady    = ir;
    sampleIn   = data;
    newFrame   = nf;
    vol        = v;
    clearFlags = clr;
    sz    = modelQ.size();
    full  = (sz == 8);
    pop   = nf && modelRun && (sz > 0);
    ufEvt = nf && modelRun && (sz == 0);
    ofEvt = ir && full && !pop;
    wr    = ir && (!full || pop);
    nextRun = modelRun ? !ufEvt : (sz >= 4);
    if (pop) begin
      head     = modelQ.pop_front();
      modelOut = head >>> v;
    end
    if (wr) modelQ.push_back(data);
    modelValid = nf;
    modelRun   = nextRun;
    if (ufEvt) modelUf = 1'b1; else if (clr) modelUf = 1'b0;
    if (ofEvt) modelOf = 1'b1; else if (clr) modelOf = 1'b0;
    @(posedge clk);
    #1;
    compareAll(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(1'b0, 16'sd0, 1'b0, 3'd0, 1'b0, tag);
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge.
  task automatic pulseReset(input string tag);
    @(negedge clk);
    inReady = 1'b0; newFrame = 1'b0; clearFlags = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    resetModel();
    checkOutput({tag, ".out"},   int'(sampleOut), 0);
    checkOutput({tag, ".valid"}, int'(sampleValid), 0);
    checkOutput({tag, ".fill"},  int'(fillLevel), 0);
    checkOutput({tag, ".uf"},    int'(underflow), 0);
    checkOutput({tag, ".of"},    int'(overflow), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; inReady = 1'b0; newFrame = 1'b0; sampleIn = '0; vol = '0; clearFlags = 1'b0;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    compareAll("reset");
    @(negedge clk);
    reset = 1'b0;

    // Prime with four samples, let FILL see the count, then the first frame pops 100.
    applyStimulus(1, 16'sd100, 0, 0, 0, "t1.w");
    applyStimulus(1, 16'sd200, 0, 0, 0, "t1.w");
    applyStimulus(1, 16'sd300, 0, 0, 0, "t1.w");
    applyStimulus(1, 16'sd400, 0, 0, 0, "t1.w");
    idle("t1.prime");
    applyStimulus(0, 16'sd0, 1, 0, 0, "t1.pop");
    checkOutput("t1.first", int'($signed(sampleOut)), 100);
    checkOutput("t1.fill3", int'(fillLevel), 3);
    checkOutput("t1.valid", int'(sampleValid), 1);

    // Attenuation of negative samples.
    applyStimulus(1, -16'sd1000, 0, 0, 0, "t2.w");
    applyStimulus(1, -16'sd1, 0, 0, 0, "t2.w");
    applyStimulus(0, 16'sd0, 1, 0, 0, "t2.pop");
    applyStimulus(0, 16'sd0, 1, 0, 0, "t2.pop");
    applyStimulus(0, 16'sd0, 1, 0, 0, "t2.pop");
    applyStimulus(0, 16'sd0, 1, 3'd2, 0, "t2.vol2");
    checkOutput("t2.m1000v2", int'($signed(sampleOut)), -250);
    applyStimulus(0, 16'sd0, 1, 3'd7, 0, "t2.vol7");
    checkOutput("t2.m1v7", int'($signed(sampleOut)), -1);

    // Empty pop in RUN: hold value, flag underflow, then re-prime before popping again.
    applyStimulus(0, 16'sd0, 1, 0, 0, "t4.under");
    checkOutput("t4.uf", int'(underflow), 1);
    checkOutput("t4.hold", int'($signed(sampleOut)), -1);
    applyStimulus(1, 16'sd11, 0, 0, 0, "t4.w");
    applyStimulus(1, 16'sd22, 0, 0, 0, "t4.w");
    applyStimulus(1, 16'sd33, 1, 0, 0, "t4.nopop");
    checkOutput("t4.fill3", int'(fillLevel), 3);
    applyStimulus(1, 16'sd44, 0, 0, 0, "t4.w");
    idle("t4.prime");
    applyStimulus(0, 16'sd0, 1, 0, 1, "t4.pop");
    checkOutput("t4.re", int'($signed(sampleOut)), 11);
    checkOutput("t4.clr", int'(underflow), 0);

    // Overflow: nine writes with no pops.
    pulseReset("t6a");
    for (int i = 0; i < 9; i++) applyStimulus(1, 16'(1000 + i), 0, 0, 0, "t3.w");
    checkOutput("t3.fill8", int'(fillLevel), 8);
    checkOutput("t3.of", int'(overflow), 1);
    applyStimulus(0, 16'sd0, 0, 0, 1, "t3.clr");
    checkOutput("t3.ofclr", int'(overflow), 0);

    // Full buffer with write and pop together: no overflow, pointers wrap repeatedly.
    for (int i = 0; i < 20; i++) applyStimulus(1, 16'(2000 + i), 1, 0, 0, "t5.wp");
    checkOutput("t5.fill", int'(fillLevel), 8);
    checkOutput("t5.of", int'(overflow), 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 16'sd0, 1, 0, 0, "t5.drain");
    checkOutput("t5.last", int'($signed(sampleOut)), 2019);

    // Reset in the middle of traffic.
    applyStimulus(1, 16'sd5, 0, 0, 0, "t6.w");
    applyStimulus(1, 16'sd6, 1, 0, 0, "t6.w");
    pulseReset("t6b");

    // Random traffic, with an occasional reset.
    for (int i = 0; i < 1500; i++) begin
      if (($urandom % 400) == 0) begin
        pulseReset("rnd.rst");
      end else begin
        applyStimulus(($urandom % 100) < 55, 16'($urandom), ($urandom % 100) < 45,
                      3'($urandom), ($urandom % 100) < 5, "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
